// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier with valid/ready handshakes and runtime signed/unsigned mode.
// Optional early termination when the remaining multiplier bits are zero: define SEQ_MULT_EARLY_TERM_EN.
`timescale 1ns/1ps
module seq_mult_hs #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   ONE_CNT = CNT_W'(1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]           state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     count;
    logic                 neg_flag;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     mplier_next;
    logic                 last_iter;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);

    // Signed operands are reduced to magnitudes; -2^(W-1) maps onto itself, which reads as the correct unsigned magnitude.
    always_comb begin
        mag_a = a;
        mag_b = b;
        if (signed_mode && a[WIDTH-1]) mag_a = ~a + ONE_W;
        if (signed_mode && b[WIDTH-1]) mag_b = ~b + ONE_W;
    end

    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mplier_next = mplier >> 1;
        product     = neg_flag ? (~acc_next + ONE_2W) : acc_next;
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_iter   = (count == LAST_CNT) || (mplier_next == '0);
`else
        last_iter   = (count == LAST_CNT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            count    <= '0;
            neg_flag <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand    <= {{WIDTH{1'b0}}, mag_a};
                        mplier   <= mag_b;
                        acc      <= '0;
                        count    <= '0;
                        neg_flag <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    count  <= count + ONE_CNT;
                    // The final partial product is folded straight into result on the exit edge.
                    if (last_iter) begin
                        result <= product;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed self-checking bench for seq_mult_hs (WIDTH=8); expected latencies follow SEQ_MULT_EARLY_TERM_EN.
`timescale 1ns/1ps
module tb_seq_mult_hs;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;

    int checks;
    int failures;

    seq_mult_hs #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic sm,
                          input logic [15:0] exp_res, input int lat_full, input int lat_early,
                          input string name, input bit release_after);
        int  exp_lat;
        int  lat;
        bit  seen;
`ifdef SEQ_MULT_EARLY_TERM_EN
        exp_lat = lat_early;
`else
        exp_lat = lat_full;
`endif
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s in_ready_before: got %b expected 1", name, in_ready);
        end
        a = op_a; b = op_b; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: got busy=%b in_ready=%b expected busy=1 in_ready=0", name, busy, in_ready);
        end
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout: out_valid not seen within %0d edges", name, lat);
        end else begin
            if (lat != exp_lat) begin
                failures++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
            end
            checks++;
            if (result !== exp_res) begin
                failures++;
                $display("FAIL %s result: got %h expected %h", name, result, exp_res);
            end
        end
        if (release_after) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== exp_res) begin
                failures++;
                $display("FAIL %s release: got ov=%b ir=%b busy=%b res=%h expected ov=0 ir=1 busy=0 res=%h",
                         name, out_valid, in_ready, busy, result, exp_res);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 8'h12; b = 8'h34; signed_mode = 1'b0; out_ready = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: got ir=%b ov=%b busy=%b res=%h expected ir=1 ov=0 busy=0 res=0000",
                     in_ready, out_valid, busy, result);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold: got busy=%b ir=%b expected busy=0 ir=1", busy, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got busy=%b ov=%b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_unsigned();
        out_ready = 1'b1;
        run_op(8'd3,   8'd5,   1'b0, 16'h000F, 8, 3, "u_3x5",     1);
        run_op(8'd255, 8'd255, 1'b0, 16'hFE01, 8, 8, "u_255x255", 1);
        run_op(8'h00,  8'h37,  1'b0, 16'h0000, 8, 6, "u_0x55",    1);
    endtask

    task automatic test_signed();
        out_ready = 1'b1;
        run_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, 8, 3, "s_m3x5",      1);
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, 8, 8, "s_m128xm128", 1);
        run_op(8'h80, 8'h01, 1'b1, 16'hFF80, 8, 1, "s_m128x1",    1);
        run_op(8'h05, 8'hFD, 1'b1, 16'hFFF1, 8, 2, "s_5xm3",      1);
        run_op(8'hFF, 8'hFF, 1'b1, 16'h0001, 8, 1, "s_m1xm1",     1);
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        run_op(8'h23, 8'h01, 1'b0, 16'h0023, 8, 1, "lat_b1",  1);
        run_op(8'h23, 8'h10, 1'b0, 16'h0230, 8, 5, "lat_b10", 1);
        run_op(8'h5A, 8'h00, 1'b0, 16'h0000, 8, 1, "lat_b0",  1);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        run_op(8'h0C, 8'h0B, 1'b0, 16'h0084, 8, 4, "bp_12x11", 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h55; b = 8'h33;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 16'h0084 || in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got ov=%b res=%h ir=%b busy=%b expected ov=1 res=0084 ir=0 busy=1",
                         i, out_valid, result, in_ready, busy);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 16'h0084) begin
            failures++;
            $display("FAIL bp_release: got ov=%b ir=%b busy=%b res=%h expected ov=0 ir=1 busy=0 res=0084",
                     out_valid, in_ready, busy, result);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_new_op: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        @(negedge clk);
        a = 8'h11; b = 8'hC3; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_running: got busy=%b ov=%b expected busy=1 ov=0", busy, out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 16'h0000) begin
            failures++;
            $display("FAIL rst_mid_outputs: got ov=%b ir=%b busy=%b res=%h expected ov=0 ir=1 busy=0 res=0000",
                     out_valid, in_ready, busy, result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_discard: got ov=%b busy=%b expected 0 0", out_valid, busy);
        end
        run_op(8'd7, 8'd9, 1'b0, 16'h003F, 8, 4, "rst_then_7x9", 1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_latency();
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
